dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/rr_pick2.sv | 15 +
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
package dmem_arb_pkg;
    localparam int DMEM_ADDR_W = 13;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-request round-robin picker: a lone request always wins, a tie goes to ptr.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory; one transaction
// in flight, fixed IDLE -> ISSUE -> RESP sequence with round-robin on ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data
);
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              ptr;
    logic              owner;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [1:0]        grant;
    logic              hs;

    rr_pick2 u_pick (
        .req   ({p1_valid, p0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    assign hs       = (state == IDLE) && (|grant);
    assign p0_ready = (state == IDLE) && grant[0];
    assign p1_ready = (state == IDLE) && grant[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command and owner are captured only at the handshake, so the memory
    // address/data lines hold their value until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ptr       <= grant[0];
                owner     <= grant[1];
                cmd_we    <= grant[1] ? p1_we    : p0_we;
                cmd_addr  <= grant[1] ? p1_addr  : p0_addr;
                cmd_wdata <= grant[1] ? p1_wdata : p0_wdata;
            end
        end
    end

    // Strobes and rvalid decode straight from state so an asynchronous reset
    // removes them immediately.
    assign mem_address    = cmd_addr;
    assign mem_write_data = cmd_wdata;
    assign mem_memwrite   = (state == ISSUE) && cmd_we;
    assign mem_memread    = (state == ISSUE) && !cmd_we;

    assign p0_rvalid = (state == RESP) && !owner;
    assign p1_rvalid = (state == RESP) && owner;
    assign p0_rdata  = mem_read_data;
    assign p1_rdata  = mem_read_data;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random bench for dmem_arbiter with a behavioural memory model.
module tb_dmem_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid, p0_we, p0_ready, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_valid, p1_we, p1_ready, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_memread, mem_memwrite;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0_valid       (p0_valid),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_ready       (p0_ready),
        .p0_rvalid      (p0_rvalid),
        .p0_rdata       (p0_rdata),
        .p1_valid       (p1_valid),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_ready       (p1_ready),
        .p1_rvalid      (p1_rvalid),
        .p1_rdata       (p1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_read_data  (mem_read_data)
    );

    // Memory: writes and registered reads on the strobed posedge.
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_address] <= mem_write_data;
        if (mem_memread)  mem_read_data    <= mem[mem_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Strobe invariants watched continuously.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_memread || mem_memwrite) begin
                check("strobe_exclusive", {62'd0, mem_memread, mem_memwrite}, {62'd0, ~mem_memwrite, ~mem_memread});
                check("strobe_one_cycle", {63'd0, prev_strobe}, 64'd0);
            end
        end
        prev_strobe = mem_memread || mem_memwrite;
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
        logic got;
        @(posedge clk); #1;
        if (port) begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (port ? p1_ready : p0_ready) got = 1'b1;
            else @(posedge clk);
        end
        check("hs_ready", 64'(got), 64'd1);
        if (!got) begin
            p0_valid = 1'b0; p1_valid = 1'b0;
            return;
        end
        check("hs_other_ready", 64'(port ? p0_ready : p1_ready), 64'd0);
        check("hs_no_strobe", 64'({mem_memread, mem_memwrite}), 64'd0);
        @(posedge clk); #1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk);
        check("issue_memwrite", 64'(mem_memwrite), 64'(we));
        check("issue_memread", 64'(mem_memread), 64'(!we));
        check("issue_addr", 64'(mem_address), 64'(addr));
        if (we) check("issue_wdata", 64'(mem_write_data), 64'(wdata));
        check("issue_no_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
        check("issue_no_ready", 64'({p1_ready, p0_ready}), 64'd0);
        @(negedge clk);
        check("resp_no_strobe", 64'({mem_memread, mem_memwrite}), 64'd0);
        check("resp_rvalid", 64'({p1_rvalid, p0_rvalid}), port ? 64'd2 : 64'd1);
        check("resp_addr_stable", 64'(mem_address), 64'(addr));
        if (!we) check("resp_rdata", 64'(port ? p1_rdata : p0_rdata), 64'(exp));
        if (we) ref_mem[int'(addr)] = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rp;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        vecs[0] = {1'b0, 1'b1, 13'h0000, 32'h12345678, 32'h0};
        vecs[1] = {1'b1, 1'b0, 13'h0000, 32'h0,        32'h12345678};
        vecs[2] = {1'b1, 1'b1, 13'h1FFF, 32'hDEADBEEF, 32'h0};
        vecs[3] = {1'b0, 1'b0, 13'h1FFF, 32'h0,        32'hDEADBEEF};
        vecs[4] = {1'b0, 1'b1, 13'h0010, 32'hA5A5A5A5, 32'h0};
        vecs[5] = {1'b1, 1'b1, 13'h0010, 32'h0000FFFF, 32'h0};
        vecs[6] = {1'b0, 1'b0, 13'h0010, 32'h0,        32'h0000FFFF};
        vecs[7] = {1'b1, 1'b0, 13'h0005, 32'h0,        32'h0};

        rst_n = 1'b0;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        #12;
        check("rst_strobes", 64'({mem_memread, mem_memwrite}), 64'd0);
        check("rst_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", 64'(mem_write_data), 64'd0);
        check("rst_ready_idle", 64'({p1_ready, p0_ready}), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Both ports request continuously: grants alternate p0, p1 every 3 cycles.
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 13'h0010;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 13'h1FFF;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            check("alt_p0_ready", 64'(p0_ready), 64'(cyc % 6 == 0));
            check("alt_p1_ready", 64'(p1_ready), 64'(cyc % 6 == 3));
            check("alt_p0_rvalid", 64'(p0_rvalid), 64'(cyc % 6 == 2));
            check("alt_p1_rvalid", 64'(p1_rvalid), 64'(cyc % 6 == 5));
            if (cyc % 6 == 2) check("alt_p0_rdata", 64'(p0_rdata), 64'h0000FFFF);
            if (cyc % 6 == 5) check("alt_p1_rdata", 64'(p1_rdata), 64'hDEADBEEF);
        end
        p0_valid = 1'b0; p1_valid = 1'b0;

        // Reset during ISSUE of a p1 write aborts it.
        @(posedge clk); #1;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 13'h0005; p1_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("abort_hs", 64'(p1_ready), 64'd1);
        @(posedge clk); #1;
        p1_valid = 1'b0;
        @(negedge clk);
        check("abort_issue_write", 64'(mem_memwrite), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_strobe_drop", 64'({mem_memread, mem_memwrite}), 64'd0);
        check("abort_addr_clear", 64'(mem_address), 64'd0);
        @(negedge clk);
        check("abort_no_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
        #1 rst_n = 1'b1;
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 13'h0005;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 13'h0000;
        #1;
        check("post_rst_p0_ready", 64'(p0_ready), 64'd1);
        check("post_rst_p1_ready", 64'(p1_ready), 64'd0);
        @(posedge clk); #1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk);
        check("post_rst_memread", 64'(mem_memread), 64'd1);
        @(negedge clk);
        check("post_rst_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd1);
        check("post_rst_rdata_unwritten", 64'(p0_rdata), 64'd0);

        // Random single-port traffic against the reference contents.
        for (int n = 0; n < 40; n++) begin
            rp = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ra = 13'h0010;
                1:       ra = 13'h1FFF;
                2:       ra = 13'h0005;
                default: ra = AW'($urandom_range(0, (1 << AW) - 1));
            endcase
            rd = $urandom;
            do_txn(rp, rw, ra, rd, ref_rd(ra));
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
